inst_fetch_unit: RTL and testbench
==================================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port rst  in  1  reset, asynchronous, active-high.
REQ-004 Port imem_req  out  1  instruction-memory request valid.
REQ-005 Port imem_addr  out  32  request byte address, word aligned.
REQ-006 Port imem_gnt  in  1  memory accepts the request this cycle.
REQ-007 Port imem_rvalid  in  1  read data valid, at least 1 cycle after grant.
REQ-008 Port imem_rdata  in  32  fetched instruction word.
REQ-009 Port redirect_valid  in  1  branch/jump redirect strobe.
REQ-010 Port redirect_pc  in  32  redirect target.
REQ-011 Port instr_valid  out  1  head of fetch buffer is valid.
REQ-012 Port instr_word  out  32  instruction to the decoder (instruction_word).
REQ-013 Port instr_pc  out  32  PC of instr_word.
REQ-014 Port instr_ready  in  1  decoder consumes head when high with instr_valid.

Function
REQ-015 The block SHALL hold a 32-bit fetch PC, a 2-entry FIFO of {word, pc}, and a 3-state FSM: REQ, WAIT, DISCARD.
REQ-016 The block SHALL allow at most one outstanding memory request.
REQ-017 In REQ, imem_req SHALL be 1 iff FIFO count < 2; imem_addr SHALL equal the fetch PC.
REQ-018 A request SHALL be accepted on imem_req & imem_gnt: the FSM goes to WAIT, the PC of the in-flight request is latched, and the fetch PC advances by 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-019 In WAIT, imem_req SHALL be 0. On imem_rvalid, the block pushes {imem_rdata, latched PC} and the FSM returns to REQ.
REQ-020 The head SHALL pop when instr_valid & instr_ready. Push and pop in the same cycle leave the count unchanged.
REQ-021 instr_valid SHALL equal (count != 0). instr_word/instr_pc SHALL show the head entry combinationally from registers. When the FIFO is empty they read 32'h0000_0013 (NOP) and 0.
REQ-022 On redirect_valid, the block SHALL flush the FIFO (count 0, pending pop ignored) and load the fetch PC with {redirect_pc[31:2], 2'b00}.
REQ-023 For redirect handling, a request is in flight if the FSM is in WAIT without imem_rvalid, or in REQ with a grant this cycle. Redirect while a request is in flight SHALL move the FSM to DISCARD; otherwise it moves to REQ.
REQ-024 Redirect in WAIT in the same cycle as imem_rvalid SHALL drop that data and go to REQ.
REQ-025 In DISCARD, imem_req SHALL be 0. The next imem_rvalid SHALL be dropped (no push) and the FSM goes to REQ.
REQ-026 A further redirect while in DISCARD SHALL update the fetch PC and keep the FSM in DISCARD.
REQ-027 Redirect has priority over push, pop, and PC increment in the same cycle.
REQ-028 imem_rvalid in REQ SHALL be ignored. imem_gnt without imem_req SHALL be ignored.

Reset
REQ-029 While rst is high: FSM=REQ, fetch PC=RESET_PC, FIFO count=0, imem_req=0, instr_valid=0, instr_word=32'h0000_0013, instr_pc=0.
REQ-030 rst asserted mid-transaction SHALL abandon any outstanding request. A late imem_rvalid after rst release, arriving while in REQ, is ignored per REQ-028.
REQ-031 In the first cycle after rst deasserts, imem_req SHALL be 1 with imem_addr=RESET_PC.

Verification
REQ-032 Streaming: gnt always 1, rvalid 1 cycle after gnt, instr_ready=1 -> decoder sees instr_pc 0,4,8,... in order with matching words (e.g. 32'h0042_82B3 at PC 0).
REQ-033 Backpressure: instr_ready=0 -> exactly 2 entries buffered, imem_req stays 0. Then instr_ready=1 -> both entries pop in order, and fetch resumes at PC 8.
REQ-034 Redirect in WAIT to 32'h0000_0102 -> in-flight response dropped, FIFO empty, next imem_addr=32'h0000_0100, and the first delivered instr_pc=32'h0000_0100.
REQ-035 Redirect coincident with imem_rvalid, and separately coincident with a grant -> no stale word is ever delivered (checked by scoreboard).
REQ-036 Wrap: PC=32'hFFFF_FFFC fetched -> next imem_addr=0.
REQ-037 Reset asserted in WAIT -> outputs return to their REQ-029 values asynchronously, and the first post-reset request is at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: one outstanding imem request, 2-entry {word, pc} buffer, redirect/flush handling.
// Latency: request the cycle after reset or a free slot; a word is visible on instr_* the cycle after imem_rvalid.
// Backpressure: instr_ready low fills the buffer, and the unit stops requesting while it holds 2 entries.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_word,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] infl_pc_q;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic [31:0] word_q [2];
  logic [31:0] epc_q  [2];

  logic req_acc;
  logic rsp_acc;
  logic in_flight;
  logic push;
  logic pop;
  logic tail;

  // Handshake qualifiers; redirect overrides any push or pop in the same cycle.
  assign imem_req  = ~rst && (state_q == S_REQ) && (count_q != 2'd2);
  assign imem_addr = pc_q;
  assign req_acc   = imem_req & imem_gnt;
  assign rsp_acc   = (state_q == S_WAIT) & imem_rvalid;
  // A response is still owed if we are waiting and it has not arrived, or we are being granted now.
  assign in_flight = (((state_q == S_WAIT) || (state_q == S_DISCARD)) && !imem_rvalid) || req_acc;
  assign push      = rsp_acc & ~redirect_valid;
  assign pop       = instr_valid & instr_ready & ~redirect_valid;
  assign tail      = head_q ^ count_q[0];

  // Head of buffer drives the decoder; empty buffer presents a NOP at PC 0.
  assign instr_valid = (count_q != 2'd0);
  assign instr_word  = instr_valid ? word_q[head_q] : NOP;
  assign instr_pc    = instr_valid ? epc_q[head_q]  : 32'h0000_0000;

  // Fetch FSM: redirect decides between REQ and DISCARD depending on an owed response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
    end else if (redirect_valid) begin
      state_q <= in_flight ? S_DISCARD : S_REQ;
    end else begin
      case (state_q)
        S_REQ:     if (req_acc)     state_q <= S_WAIT;
        S_WAIT:    if (imem_rvalid) state_q <= S_REQ;
        S_DISCARD: if (imem_rvalid) state_q <= S_REQ;
        default:                    state_q <= S_REQ;
      endcase
    end
  end

  // Next fetch PC and buffer occupancy; redirect wins over increment, push and pop.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      count_d = 2'd0;
      head_d  = 1'b0;
    end else begin
      if (req_acc) pc_d = pc_q + 32'd4;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) head_d = ~head_q;
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC & 32'hFFFF_FFFC;
      infl_pc_q <= 32'h0000_0000;
      count_q   <= 2'd0;
      head_q    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      if (req_acc) infl_pc_q <= pc_q;
    end
  end

  // Buffer storage; contents are only meaningful under count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      word_q[tail] <= imem_rdata;
      epc_q[tail]  <= infl_pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  inst_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_word(instr_word), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Memory model state and architectural expectations.
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  logic [31:0] exp_fetch;
  logic [31:0] exp_dec;
  int          npops;
  int          ngrants;
  logic [31:0] first_pop_pc;
  bit          chk_flush;
  logic [31:0] prev_gnt_addr;
  bit          seen_wrap;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0042_82B3;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive at negedge, check and update the model 1ns later.
  task automatic step(input bit gnt, input bit rdy, input bit redir, input logic [31:0] tgt, input int lat);
    bit rv;
    @(negedge clk);
    rv = pend && (pend_cnt == 0);
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_word(pend_addr) : $urandom;
    imem_gnt       = gnt;
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    #1;
    if (chk_flush) begin
      tests++;
      if (instr_valid !== 1'b0) begin fails++; $display("FAIL flush: instr_valid=%b required 0", instr_valid); end
      chk_flush = 0;
    end
    if (imem_req === 1'b1) begin
      tests++;
      if (imem_addr !== exp_fetch) begin fails++; $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, exp_fetch); end
      tests++;
      if (pend) begin fails++; $display("FAIL single_outstanding: imem_req=1 with request pending, required 0"); end
    end
    if (instr_valid === 1'b1 && rdy && !redir) begin
      tests++;
      if (instr_pc !== exp_dec || instr_word !== mem_word(exp_dec)) begin
        fails++;
        $display("FAIL deliver: pc=%h word=%h required pc=%h word=%h", instr_pc, instr_word, exp_dec, mem_word(exp_dec));
      end
      if (npops == 0) first_pop_pc = instr_pc;
      npops++;
      exp_dec = exp_dec + 32'd4;
    end
    if (rv) pend = 0;
    else if (pend) pend_cnt--;
    if (imem_req === 1'b1 && gnt) begin
      if (imem_addr == 32'h0 && prev_gnt_addr == 32'hFFFF_FFFC) seen_wrap = 1;
      prev_gnt_addr = imem_addr;
      pend      = 1;
      pend_addr = imem_addr;
      pend_cnt  = lat;
      ngrants++;
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redir) begin
      exp_fetch = tgt & 32'hFFFF_FFFC;
      exp_dec   = exp_fetch;
      chk_flush = 1;
    end
  endtask

  task automatic clear_model();
    pend = 0; pend_cnt = 0; pend_addr = 0;
    exp_fetch = RPC; exp_dec = RPC;
    npops = 0; ngrants = 0; chk_flush = 0;
    prev_gnt_addr = 32'h0; seen_wrap = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (imem_req !== 1'b0) begin fails++; $display("FAIL %s_req: imem_req=%b required 0", tag, imem_req); end
    tests++;
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL %s_valid: instr_valid=%b required 0", tag, instr_valid); end
    tests++;
    if (instr_word !== 32'h0000_0013) begin fails++; $display("FAIL %s_word: instr_word=%h required 00000013", tag, instr_word); end
    tests++;
    if (instr_pc !== 32'h0) begin fails++; $display("FAIL %s_pc: instr_pc=%h required 0", tag, instr_pc); end
  endtask

  task automatic release_and_check(input string tag);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      fails++; $display("FAIL %s_first_req: req=%b addr=%h required req=1 addr=%h", tag, imem_req, imem_addr, RPC);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; imem_gnt = 0; imem_rvalid = 0; redirect_valid = 0; instr_ready = 0;
    #1;
    check_reset_outputs("reset");
    clear_model();
    release_and_check("reset");
  endtask

  task automatic test_stream();
    test_reset();
    for (int i = 0; i < 40; i++) step(1, 1, 0, 32'h0, 0);
    tests++;
    if (npops < 15 || first_pop_pc !== 32'h0) begin
      fails++; $display("FAIL stream: pops=%0d first_pc=%h required >=15 pops from pc 0", npops, first_pop_pc);
    end
  endtask

  task automatic test_backpressure();
    test_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 32'h0, 0);
    tests++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      fails++; $display("FAIL bp_full: valid=%b req=%b required valid=1 req=0", instr_valid, imem_req);
    end
    tests++;
    if (ngrants != 2 || pend) begin
      fails++; $display("FAIL bp_grants: grants=%0d pending=%0d required 2 and 0", ngrants, pend);
    end
    step(0, 1, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    tests++;
    if (npops != 2) begin fails++; $display("FAIL bp_pops: pops=%0d required 2", npops); end
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      fails++; $display("FAIL bp_resume: req=%b addr=%h required req=1 addr=00000008", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    test_reset();
    step(1, 1, 0, 32'h0, 2);
    step(0, 1, 1, 32'h0000_0102, 0);
    step(0, 1, 0, 32'h0, 0);
    tests++;
    if (imem_req !== 1'b0) begin fails++; $display("FAIL discard_req: imem_req=%b required 0", imem_req); end
    step(0, 1, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 0);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
      fails++; $display("FAIL redirect_addr: req=%b addr=%h required req=1 addr=00000100", imem_req, imem_addr);
    end
    for (int i = 0; i < 10 && npops == 0; i++) step(1, 1, 0, 32'h0, 0);
    tests++;
    if (npops == 0 || first_pop_pc !== 32'h0000_0100) begin
      fails++; $display("FAIL redirect_first: pops=%0d first_pc=%h required pc 00000100", npops, first_pop_pc);
    end
  endtask

  task automatic test_redirect_coincident();
    test_reset();
    step(1, 1, 0, 32'h0, 0);
    step(1, 1, 1, 32'h0000_0200, 0);
    step(1, 1, 1, 32'h0000_0300, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 32'h0, 0);
    tests++;
    if (npops == 0 || first_pop_pc !== 32'h0000_0300) begin
      fails++; $display("FAIL coincident: pops=%0d first_pc=%h required pc 00000300", npops, first_pop_pc);
    end
  endtask

  task automatic test_wrap();
    test_reset();
    step(0, 1, 1, 32'hFFFF_FFF9, 0);
    for (int i = 0; i < 30; i++) step(1, 1, 0, 32'h0, 0);
    tests++;
    if (!seen_wrap || npops < 5) begin
      fails++; $display("FAIL wrap: seen_wrap=%0d pops=%0d required wrap to 0", seen_wrap, npops);
    end
  endtask

  task automatic test_reset_in_wait();
    test_reset();
    step(1, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 3);
    step(0, 0, 0, 32'h0, 0);
    #2;
    tests++;
    if (instr_valid !== 1'b1) begin fails++; $display("FAIL rstwait_pre: instr_valid=%b required 1", instr_valid); end
    rst = 1'b1;
    #1;
    check_reset_outputs("rstwait");
    imem_gnt = 0; instr_ready = 0;
    clear_model();
    release_and_check("rstwait");
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    bit redir;
    test_reset();
    for (int i = 0; i < 3000; i++) begin
      redir = ($urandom_range(0, 19) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step($urandom_range(0, 1), $urandom_range(0, 3) != 0, redir, tgt, $urandom_range(0, 3));
    end
    tests++;
    if (npops < 100) begin fails++; $display("FAIL random_progress: pops=%0d required >=100", npops); end
  endtask

  initial begin
    rst = 1'b1;
    clear_model();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_coincident();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
